vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing.sv | 104 ++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Video bus between the timing generator and the game engine / DAC side.
// The timing block owns coordinates, sync and colour; the engine supplies pixel.
`timescale 1ns/1ps
interface vga_timing_if;
  logic [2:0]  pixel;
  logic [10:0] pixel_h;
  logic [10:0] pixel_v;
  logic        frame_start;
  logic        vga_red;
  logic        vga_green;
  logic        vga_blue;
  logic        vga_hsync;
  logic        vga_vsync;

  modport master (
    input  pixel,
    output pixel_h, pixel_v, frame_start,
    output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync
  );

  modport slave (
    output pixel,
    input  pixel_h, pixel_v, frame_start,
    input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: h/v counters, delayed active/sync flags
// and registered colour gated by the delayed active flag.
`timescale 1ns/1ps
module vga_timing #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FRONT    = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BACK     = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FRONT    = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BACK     = 23,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic          i_vga_clock,
  input  logic          i_reset_n,
  vga_timing_if.master  bus
);

  localparam int unsigned CW       = 11;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned F_ACT    = 2;
  localparam int unsigned F_HS     = 1;
  localparam int unsigned F_VS     = 0;

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic          r_frame_start;
  logic [2:0]    r_pipe [PIPE_DELAY];
  logic [2:0]    r_rgb;
  logic          r_hsync;
  logic          r_vsync;

  logic          w_h_last;
  logic          w_v_last;
  logic [2:0]    w_flags;
  logic [2:0]    w_tail;

  assign w_h_last = (r_h == CW'(H_TOTAL - 1));
  assign w_v_last = (r_v == CW'(V_TOTAL - 1));

  // Raster flags for the coordinate currently on the counters.
  assign w_flags[F_ACT] = (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACTIVE));
  assign w_flags[F_HS]  = (r_h >= CW'(HS_START)) && (r_h <= CW'(HS_END));
  assign w_flags[F_VS]  = (r_v >= CW'(VS_START)) && (r_v <= CW'(VS_END));
  assign w_tail         = r_pipe[PIPE_DELAY-1];

  always_ff @(posedge i_vga_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_h           <= '0;
      r_v           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_last ? '0 : r_h + CW'(1);
      if (w_h_last) begin
        r_v <= w_v_last ? '0 : r_v + CW'(1);
      end
      // Pulse lands on the cycle the counters show (0,0) after a frame wrap.
      r_frame_start <= w_h_last && w_v_last;
    end
  end

  // Flag delay line, matched to the engine's pixel latency.
  always_ff @(posedge i_vga_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(PIPE_DELAY); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_flags;
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(posedge i_vga_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rgb   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_rgb   <= bus.pixel & {3{w_tail[F_ACT]}};
      r_hsync <= w_tail[F_HS] ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_tail[F_VS] ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign bus.pixel_h     = r_h;
  assign bus.pixel_v     = r_v;
  assign bus.frame_start = r_frame_start;
  assign bus.vga_red     = r_rgb[2];
  assign bus.vga_green   = r_rgb[1];
  assign bus.vga_blue    = r_rgb[0];
  assign bus.vga_hsync   = r_hsync;
  assign bus.vga_vsync   = r_vsync;

endmodule
